// File: rtl/led_matrix_scan_8x8.sv
// 8x8 LED matrix row scanner with a double-buffered frame and per-slot blanking.
// The pending frame is swapped into the display buffer only at row-0 slot starts.
module led_matrix_scan_8x8 #(
  parameter int unsigned CLK_DIV      = 12000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter logic        ROW_ON_LVL   = 1'b1,
  parameter logic        COL_ON_LVL   = 1'b0
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_ENABLE,
  input  logic [63:0] i_FRAME,
  input  logic        i_FRAME_VALID,
  output logic        o_FRAME_READY,
  output logic        o_FRAME_START,
  output logic [7:0]  o_ROWS,
  output logic [7:0]  o_COLUMNS
);

  localparam int unsigned   PW          = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 32'd1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [7:0] ROWS_OFF = {8{~ROW_ON_LVL}};
  localparam logic [7:0] COLS_OFF = {8{~COL_ON_LVL}};

  logic [1:0]    state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   display_q, display_d;
  logic [63:0]   pending_q, pending_d;
  logic          pending_full_q, pending_full_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    rows_q, rows_d;
  logic [7:0]    cols_q, cols_d;
  logic          boundary_s;
  logic          accept_s;
  logic [7:0]    row_bits_s;
  logic [7:0]    row_onehot_s;

  // Next-state, buffer handoff and output pin computation.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    presc_d        = presc_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    boundary_s     = 1'b0;
    accept_s       = i_FRAME_VALID & ~pending_full_q;

    if (!i_ENABLE) begin
      state_d = ST_IDLE;
      row_d   = 3'd0;
      presc_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_BLANK;
      row_d      = 3'd0;
      presc_d    = '0;
      boundary_s = 1'b1;
    end else if ((state_q == ST_BLANK) || (state_q == ST_DRIVE)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d    = '0;
        row_d      = row_q + 3'd1;
        state_d    = ST_BLANK;
        boundary_s = (row_q == 3'd7);
      end else begin
        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        state_d = (presc_d < PRESC_BLANK) ? ST_BLANK : ST_DRIVE;
      end
    end else begin
      state_d = ST_IDLE;
      row_d   = 3'd0;
      presc_d = '0;
    end

    frame_start_d = boundary_s;

    // Accept only happens with pending empty, so it never collides with a swap.
    if (boundary_s && pending_full_q) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
    end else begin
      display_d = display_q;
    end

    if (accept_s) begin
      pending_d      = i_FRAME;
      pending_full_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    row_bits_s   = display_d[{row_d, 3'd0} +: 8];
    row_onehot_s = 8'd1 << row_d;

    if (state_d == ST_DRIVE) begin
      rows_d = ROW_ON_LVL ? row_onehot_s : ~row_onehot_s;
      cols_d = COL_ON_LVL ? row_bits_s : ~row_bits_s;
    end else begin
      rows_d = ROWS_OFF;
      cols_d = COLS_OFF;
    end
  end

  // State, buffers and registered pin drivers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q        <= ST_IDLE;
      row_q          <= 3'd0;
      presc_q        <= '0;
      display_q      <= 64'd0;
      pending_q      <= 64'd0;
      pending_full_q <= 1'b0;
      frame_start_q  <= 1'b0;
      rows_q         <= ROWS_OFF;
      cols_q         <= COLS_OFF;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      presc_q        <= presc_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      frame_start_q  <= frame_start_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
    end
  end

  assign o_FRAME_READY = ~pending_full_q;
  assign o_FRAME_START = frame_start_q;
  assign o_ROWS        = rows_q;
  assign o_COLUMNS     = cols_q;

endmodule

// File: tb/tb_led_matrix_scan_8x8.sv
// Directed bench for led_matrix_scan_8x8 with CLK_DIV=8, BLANK_CYCLES=2:
// a vector table of scan positions plus sequences for handshake, enable and reset.
module tb_led_matrix_scan_8x8;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [63:0] frame;
  logic        valid;
  logic        ready;
  logic        fstart;
  logic [7:0]  rows;
  logic [7:0]  cols;

  int errors;
  int checks;
  int pos;

  typedef struct {
    logic [63:0] frame;
    int          pos;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic        start;
  } vec_t;

  vec_t vecs[12];

  led_matrix_scan_8x8 #(
    .CLK_DIV(8),
    .BLANK_CYCLES(2),
    .ROW_ON_LVL(1'b1),
    .COL_ON_LVL(1'b0)
  ) dut (
    .i_CLK(clk),
    .i_RST_N(rst_n),
    .i_ENABLE(en),
    .i_FRAME(frame),
    .i_FRAME_VALID(valid),
    .o_FRAME_READY(ready),
    .o_FRAME_START(fstart),
    .o_ROWS(rows),
    .o_COLUMNS(cols)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", nm, got, exp, pos);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pos++;
  endtask

  task automatic run_to(input int p);
    while (pos < p) tick();
  endtask

  task automatic load(input logic [63:0] f);
    frame = f;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic stop_scan();
    en = 1'b0;
    tick();
  endtask

  task automatic start_scan();
    en = 1'b1;
    tick();
    pos = 0;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] r, input logic [7:0] c);
    chk({nm, "_rows"}, {56'd0, rows}, {56'd0, r});
    chk({nm, "_cols"}, {56'd0, cols}, {56'd0, c});
  endtask

  initial begin
    logic [63:0] mf;
    logic [7:0]  er;
    logic [7:0]  ec;
    int          r;
    errors = 0;
    checks = 0;
    pos    = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    frame  = 64'd0;
    valid  = 1'b0;

    vecs[0]  = '{64'h1, 0, 8'h00, 8'hFF, 1'b1};
    vecs[1]  = '{64'h1, 2, 8'h01, 8'hFE, 1'b0};
    vecs[2]  = '{64'h1, 7, 8'h01, 8'hFE, 1'b0};
    vecs[3]  = '{64'h1, 9, 8'h00, 8'hFF, 1'b0};
    vecs[4]  = '{64'h1, 10, 8'h02, 8'hFF, 1'b0};
    vecs[5]  = '{64'h1, 63, 8'h80, 8'hFF, 1'b0};
    vecs[6]  = '{64'h1, 64, 8'h00, 8'hFF, 1'b1};
    vecs[7]  = '{64'h8000_0000_0000_0000, 58, 8'h80, 8'h7F, 1'b0};
    vecs[8]  = '{64'h00FF_0000_0000_0000, 51, 8'h40, 8'h00, 1'b0};
    vecs[9]  = '{64'h0000_0000_A500_0000, 28, 8'h08, 8'h5A, 1'b0};
    vecs[10] = '{64'h0123_4567_89AB_CDEF, 4, 8'h01, 8'h10, 1'b0};
    vecs[11] = '{64'h0123_4567_89AB_CDEF, 45, 8'h20, 8'hBA, 1'b0};

    #12;
    chk_out("reset", 8'h00, 8'hFF);
    chk("reset_ready", {63'd0, ready}, 64'd1);
    chk("reset_start", {63'd0, fstart}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      stop_scan();
      load(vecs[i].frame);
      start_scan();
      run_to(vecs[i].pos);
      chk_out($sformatf("vec%0d", i), vecs[i].rows, vecs[i].cols);
      chk($sformatf("vec%0d_start", i), {63'd0, fstart}, {63'd0, vecs[i].start});
    end

    // Three full frames against a position model.
    mf = 64'h8040_2010_0804_0201;
    stop_scan();
    load(mf);
    start_scan();
    for (int p = 0; p < 192; p++) begin
      r = (p / 8) % 8;
      if ((p % 8) < 2) begin
        er = 8'h00;
        ec = 8'hFF;
      end else begin
        er = 8'h01 << r;
        ec = ~mf[r*8 +: 8];
      end
      chk_out("scan", er, ec);
      chk("scan_start", {63'd0, fstart}, {63'd0, ((p % 64) == 0)});
      tick();
    end

    // Pending held full until the next boundary; B waits one more frame.
    stop_scan();
    load(64'h0);
    start_scan();
    run_to(20);
    frame = 64'h0F;
    valid = 1'b1;
    tick();
    chk("hs_ready_after_a", {63'd0, ready}, 64'd0);
    frame = 64'hF0;
    run_to(63);
    chk("hs_ready_held", {63'd0, ready}, 64'd0);
    chk_out("hs_old", 8'h80, 8'hFF);
    tick();
    chk("hs_ready_boundary", {63'd0, ready}, 64'd1);
    chk("hs_start", {63'd0, fstart}, 64'd1);
    tick();
    chk("hs_ready_after_b", {63'd0, ready}, 64'd0);
    valid = 1'b0;
    run_to(66);
    chk_out("hs_show_a", 8'h01, 8'hF0);
    run_to(130);
    chk_out("hs_show_b", 8'h01, 8'h0F);

    // Accept on the boundary edge with pending empty: no swap yet.
    run_to(191);
    frame = 64'h3C;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("sim_start", {63'd0, fstart}, 64'd1);
    chk("sim_ready", {63'd0, ready}, 64'd0);
    run_to(194);
    chk_out("sim_noswap", 8'h01, 8'h0F);
    run_to(258);
    chk_out("sim_swap", 8'h01, 8'hC3);

    // Enable dropped mid row-5 drive.
    run_to(299);
    chk_out("en_row5", 8'h20, 8'hFF);
    en = 1'b0;
    tick();
    chk_out("en_off", 8'h00, 8'hFF);
    chk("en_off_start", {63'd0, fstart}, 64'd0);
    tick();
    tick();
    chk_out("en_parked", 8'h00, 8'hFF);
    start_scan();
    chk("en_restart", {63'd0, fstart}, 64'd1);
    chk_out("en_restart_blank", 8'h00, 8'hFF);
    run_to(2);
    chk_out("en_retained", 8'h01, 8'hC3);

    // Asynchronous reset between edges during drive.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 8'h00, 8'hFF);
    chk("arst_start", {63'd0, fstart}, 64'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", {63'd0, ready}, 64'd1);
    start_scan();
    chk("arst_fstart", {63'd0, fstart}, 64'd1);
    run_to(2);
    chk_out("arst_dark", 8'h01, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
